gamma_sequencer: RTL and testbench

// Gamma-cycle sequencer and delay scheduler for a bank of mem delay lanes.
// - Generates the gamma-cycle phase and the grst pulse that starts each cycle.
// - Holds per-lane delay configuration, double-buffered so it stays constant within a cycle.
// - Emits per-lane input spikes at the programmed delay.
// - Sits between the host config interface and the mem array; drives each lane's in and grst.

---
 rtl/tnn_pkg.sv | 21 ++
 rtl/gamma_sequencer_if.sv | 31 +++
 rtl/gamma_lane_pulse.sv | 30 +++
 rtl/gamma_sequencer.sv | 166 ++++++++++++++++
 tb/tb_gamma_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tnn_pkg.sv
// Shared types for the gamma-cycle sequencer and its lane pulse decoders.
package tnn_pkg;

    // Storage width for a lane delay. Sized for the largest supported gamma
    // cycle (2**16); narrower configs zero-extend into it.
    localparam int unsigned DELAY_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } seq_state_t;

    typedef logic [DELAY_W-1:0] delay_t;

    typedef struct packed {
        logic   en;
        delay_t delay;
    } lane_cfg_t;

endpackage

// File: rtl/gamma_sequencer_if.sv
// Host configuration write channel: valid/ready handshake carrying one lane's delay setting.
interface gamma_sequencer_if #(
    parameter int unsigned N_LANES           = 8,
    parameter int unsigned GAMMA_CYCLE_WIDTH = 128
);
    // One extra lane bit so out-of-range indices are representable and can be flagged.
    localparam int unsigned LANE_W  = $clog2(N_LANES) + 1;
    localparam int unsigned PHASE_W = $clog2(GAMMA_CYCLE_WIDTH);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [LANE_W-1:0]  cfg_lane;
    logic [PHASE_W-1:0] cfg_delay;
    logic               cfg_en;

    modport master (
        output cfg_valid,
        output cfg_lane,
        output cfg_delay,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_lane,
        input  cfg_delay,
        input  cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/gamma_lane_pulse.sv
// Per-lane spike window decoder: high while phase lies in [delay, delay+PULSE_WIDTH-1].
module gamma_lane_pulse
    import tnn_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH = 8,
    parameter int unsigned PHASE_W     = 7
) (
    input  logic               running,
    input  lane_cfg_t          cfg,
    input  logic [PHASE_W-1:0] phase,
    output logic               spike
);

    // One bit wider than the delay so delay+PULSE_WIDTH-1 never wraps; the
    // window is naturally cut off at the last phase of the cycle.
    localparam int unsigned CMP_W = DELAY_W + 1;

    logic [CMP_W-1:0] lo;
    logic [CMP_W-1:0] hi;
    logic [CMP_W-1:0] ph;

    // Window compare against the registered phase.
    always_comb begin
        lo    = {1'b0, cfg.delay};
        hi    = lo + CMP_W'(PULSE_WIDTH - 1);
        ph    = CMP_W'(phase);
        spike = running && cfg.en && (ph >= lo) && (ph <= hi);
    end

endmodule

// File: rtl/gamma_sequencer.sv
// Gamma-cycle sequencer: phase counter, grst generation, double-buffered
// per-lane delay config and per-lane spike scheduling for the mem lanes.
module gamma_sequencer
    import tnn_pkg::*;
#(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 128,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned N_LANES           = 8,
    parameter int unsigned GCNT_WIDTH        = 16
) (
    input  logic                                 aclk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 stop,
    gamma_sequencer_if.slave                     cfg,
    output logic                                 grst,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] phase,
    output logic                                 running,
    output logic [N_LANES-1:0]                   lane_spike,
    output logic [GCNT_WIDTH-1:0]                gamma_count,
    output logic                                 cfg_err
);

    localparam int unsigned PHASE_W = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int unsigned LANE_W  = $clog2(N_LANES) + 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(GAMMA_CYCLE_WIDTH - 1);

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic [PHASE_W-1:0]    phase_q;
    logic [GCNT_WIDTH-1:0] gamma_count_q;
    logic                  cfg_err_q;
    lane_cfg_t             shadow_q [N_LANES];
    lane_cfg_t             active_q [N_LANES];

    logic run_w;
    logic wrap;
    logic commit;
    logic ready_w;
    logic cfg_fire;
    logic lane_oob;

    // State register.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stop beats start; a RUN cycle ends at the wrap unless start is still held.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wrap) begin
                    if (stop || !start) begin
                        state_d = StIdle;
                    end
                end else if (stop) begin
                    state_d = StStopping;
                end
            end
            StStopping: begin
                if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and control strobes decoded from state and phase.
    always_comb begin
        run_w   = (state_q != StIdle);
        wrap    = run_w && (phase_q == LAST_PHASE);
        // Active config is reloaded on RUN entry and at every cycle wrap.
        commit  = wrap || ((state_q == StIdle) && start && !stop);
        grst    = !run_w || (phase_q == '0);
        // Hold off writes on the commit edge so a write never races the reload.
        ready_w = !wrap;
    end

    // Phase counter: parked at 0 in IDLE, free-running and wrapping while running.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else if (!run_w || wrap) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 1'b1;
        end
    end

    // Completed gamma cycles; a cycle cut short by reset is never counted.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            gamma_count_q <= '0;
        end else if (wrap) begin
            gamma_count_q <= gamma_count_q + 1'b1;
        end
    end

    always_comb begin
        cfg_fire = cfg.cfg_valid && ready_w;
        lane_oob = (32'(cfg.cfg_lane) >= N_LANES);
    end

    // Shadow config writes; out-of-range lanes are consumed and flagged sticky.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                shadow_q[i] <= '0;
            end
            cfg_err_q <= 1'b0;
        end else if (cfg_fire) begin
            if (lane_oob) begin
                cfg_err_q <= 1'b1;
            end else begin
                for (int i = 0; i < N_LANES; i++) begin
                    if (cfg.cfg_lane == LANE_W'(i)) begin
                        shadow_q[i] <= '{en: cfg.cfg_en, delay: delay_t'(cfg.cfg_delay)};
                    end
                end
            end
        end
    end

    // Active config: copied from shadow so it stays constant within a gamma cycle.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                active_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < N_LANES; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        gamma_lane_pulse #(
            .PULSE_WIDTH (PULSE_WIDTH),
            .PHASE_W     (PHASE_W)
        ) u_pulse (
            .running (run_w),
            .cfg     (active_q[g]),
            .phase   (phase_q),
            .spike   (lane_spike[g])
        );
    end

    assign cfg.cfg_ready = ready_w;
    assign phase         = phase_q;
    assign running       = run_w;
    assign gamma_count   = gamma_count_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_gamma_sequencer.sv
// Self-checking bench for gamma_sequencer (GAMMA=16, PW=4, 4 lanes) against a cycle-level model.
module tb_gamma_sequencer;

    localparam int unsigned GAMMA = 16;
    localparam int unsigned PW    = 4;
    localparam int unsigned NL    = 4;
    localparam int unsigned GW    = 16;

    logic          aclk  = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          grst;
    logic [3:0]    phase;
    logic          running;
    logic [NL-1:0] lane_spike;
    logic [GW-1:0] gamma_count;
    logic          cfg_err;
    logic [27:0]   obs;

    int errors = 0;
    int checks = 0;

    gamma_sequencer_if #(.N_LANES(NL), .GAMMA_CYCLE_WIDTH(GAMMA)) cfg_bus ();

    gamma_sequencer #(
        .GAMMA_CYCLE_WIDTH (GAMMA),
        .PULSE_WIDTH       (PW),
        .N_LANES           (NL),
        .GCNT_WIDTH        (GW)
    ) dut (
        .aclk        (aclk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg         (cfg_bus),
        .grst        (grst),
        .phase       (phase),
        .running     (running),
        .lane_spike  (lane_spike),
        .gamma_count (gamma_count),
        .cfg_err     (cfg_err)
    );

    always #5 aclk = ~aclk;

    assign obs = {grst, running, phase, lane_spike, gamma_count, cfg_err, cfg_bus.cfg_ready};

    // Behavioural model: run flag, pending stop, phase, and shadow/active config tables.
    bit m_run;
    bit m_stopping;
    int m_phase;
    int m_count;
    bit m_err;
    int m_sh_d  [NL];
    bit m_sh_en [NL];
    int m_act_d [NL];
    bit m_act_en[NL];

    function automatic void m_reset();
        m_run = 0; m_stopping = 0; m_phase = 0; m_count = 0; m_err = 0;
        for (int i = 0; i < NL; i++) begin
            m_sh_d[i] = 0; m_sh_en[i] = 0; m_act_d[i] = 0; m_act_en[i] = 0;
        end
    endfunction

    function automatic void m_commit();
        for (int i = 0; i < NL; i++) begin
            m_act_d[i] = m_sh_d[i]; m_act_en[i] = m_sh_en[i];
        end
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void m_step();
        bit accept;
        if (rst) begin
            m_reset();
            return;
        end
        accept = cfg_bus.cfg_valid && !(m_run && m_phase == GAMMA - 1);
        if (!m_run) begin
            if (start && !stop) begin
                m_commit(); m_run = 1; m_stopping = 0; m_phase = 0;
            end
        end else if (m_phase == GAMMA - 1) begin
            m_count = (m_count + 1) % (1 << GW);
            m_commit();
            m_phase = 0;
            if (m_stopping || stop || !start) begin
                m_run = 0; m_stopping = 0;
            end
        end else begin
            m_phase++;
            if (stop) m_stopping = 1;
        end
        if (accept) begin
            if (int'(cfg_bus.cfg_lane) >= NL) m_err = 1;
            else begin
                m_sh_d[cfg_bus.cfg_lane]  = int'(cfg_bus.cfg_delay);
                m_sh_en[cfg_bus.cfg_lane] = cfg_bus.cfg_en;
            end
        end
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [NL-1:0] sp;
        for (int i = 0; i < NL; i++) begin
            sp[i] = m_run && m_act_en[i] && (m_phase >= m_act_d[i])
                    && (m_phase <= m_act_d[i] + PW - 1);
        end
        return {(!m_run || m_phase == 0), m_run, 4'(m_phase), sp, 16'(m_count), m_err,
                !(m_run && m_phase == GAMMA - 1)};
    endfunction

    task automatic step();
        @(posedge aclk);
        m_step();
        #1;
    endtask

    task automatic set_cfg(input bit v, input int lane, input int d, input bit en);
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_lane  = 3'(lane);
        cfg_bus.cfg_delay = 4'(d);
        cfg_bus.cfg_en    = en;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        set_cfg(0, 0, 0, 0);
        m_reset();
        repeat (2) step();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_vec: got %h want %h", obs, exp_vec());
        end
        checks++;
        if (grst !== 1'b1 || running !== 1'b0 || phase !== 4'd0 || lane_spike !== 4'd0 ||
            gamma_count !== 16'd0 || cfg_err !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got grst=%b run=%b ph=%0d sp=%b cnt=%0d err=%b rdy=%b want 1 0 0 0000 0 0 1",
                     grst, running, phase, lane_spike, gamma_count, cfg_err, cfg_bus.cfg_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL idle_after_reset: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_idle_config();
        set_cfg(1, 0, 3, 1);
        step();
        set_cfg(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL idle_config_vec: got %h want %h", obs, exp_vec());
            end
        end
        checks++;
        if (grst !== 1'b1 || lane_spike !== 4'd0) begin
            errors++; $display("FAIL idle_quiet: got grst=%b sp=%b want 1 0000", grst, lane_spike);
        end
    endtask

    task automatic test_start();
        int pulses = 0;
        start = 1'b1;
        step();
        checks++;
        if (phase !== 4'd0 || grst !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL first_run_cycle: got ph=%0d grst=%b run=%b want 0 1 1", phase, grst, running);
        end
        for (int k = 1; k <= 33; k++) begin
            step();
            if (grst === 1'b1) pulses++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL run_vec k=%0d: got %h want %h", k, obs, exp_vec());
            end
            if (k == 1 || k == 3 || k == 6 || k == 7 || k == 19) begin
                checks++;
                if (lane_spike !== ((k % 16 >= 3 && k % 16 <= 6) ? 4'b0001 : 4'b0000)) begin
                    errors++; $display("FAIL lane0_window k=%0d: got %b", k, lane_spike);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++; $display("FAIL grst_period: got %0d pulses want 2", pulses);
        end
    endtask

    task automatic test_late_lane();
        set_cfg(1, 1, 14, 1);
        step();
        set_cfg(0, 0, 0, 0);
        for (int k = 0; k < 40 && m_phase != 0; k++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL late_lane_vec: got %h want %h", obs, exp_vec());
            end
        end
        for (int k = 0; k < 17; k++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL late_lane_vec2: got %h want %h", obs, exp_vec());
            end
            if (m_phase == 14 || m_phase == 15 || m_phase == 0 || m_phase == 13) begin
                checks++;
                if (lane_spike[1] !== (m_phase >= 14)) begin
                    errors++;
                    $display("FAIL lane1_edge ph=%0d: got %b want %b", m_phase, lane_spike[1], m_phase >= 14);
                end
            end
        end
    endtask

    task automatic test_midcycle_write();
        for (int k = 0; k < 40 && m_phase != 5; k++) step();
        checks++;
        if (m_phase != 5 || phase !== 4'd5) begin
            errors++; $display("FAIL reach_phase5: got %0d want 5", phase);
        end
        set_cfg(1, 0, 8, 1);
        step();
        set_cfg(0, 0, 0, 0);
        checks++;
        if (lane_spike[0] !== 1'b1) begin
            errors++; $display("FAIL old_delay_holds: got %b want 1 at phase 6", lane_spike[0]);
        end
        for (int k = 0; k < 40 && m_phase != 0; k++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL midwrite_vec: got %h want %h", obs, exp_vec());
            end
        end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (lane_spike[0] !== (m_phase >= 8 && m_phase <= 11)) begin
                errors++; $display("FAIL new_delay ph=%0d: got %b", m_phase, lane_spike[0]);
            end
        end
    endtask

    task automatic test_commit_stall();
        for (int k = 0; k < 40 && m_phase != 15; k++) step();
        set_cfg(1, 2, 1, 1);
        #1;
        checks++;
        if (cfg_bus.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL ready_low_at_wrap: got %b want 0", cfg_bus.cfg_ready);
        end
        step();
        checks++;
        if (cfg_bus.cfg_ready !== 1'b1 || phase !== 4'd0) begin
            errors++; $display("FAIL ready_back: got rdy=%b ph=%0d want 1 0", cfg_bus.cfg_ready, phase);
        end
        step();
        set_cfg(1, 5, 0, 1);
        step();
        set_cfg(0, 0, 0, 0);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++; $display("FAIL cfg_err_set: got %b want 1", cfg_err);
        end
        for (int k = 0; k < 24; k++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL stall_vec: got %h want %h", obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            start = ($urandom_range(0, 7) != 0);
            stop  = ($urandom_range(0, 31) == 0);
            set_cfg($urandom_range(0, 2) == 0, $urandom_range(0, 5), $urandom_range(0, 15),
                    $urandom_range(0, 3) != 0);
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_vec k=%0d: got %h want %h", k, obs, exp_vec());
            end
        end
        stop = 1'b0;
        start = 1'b1;
        set_cfg(0, 0, 0, 0);
    endtask

    task automatic test_stop();
        int cnt0;
        int n = 0;
        start = 1'b1;
        for (int k = 0; k < 64 && !(m_run && m_phase == 7); k++) step();
        cnt0 = m_count;
        stop = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b0;
        n = 1;
        for (int k = 0; k < 20 && m_run; k++) begin
            step();
            n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL stop_vec: got %h want %h", obs, exp_vec());
            end
        end
        checks++;
        if (n != 9 || running !== 1'b0 || grst !== 1'b1 || gamma_count !== 16'(cnt0 + 1)) begin
            errors++;
            $display("FAIL stop_finish: got cycles=%0d run=%b grst=%b cnt=%0d want 9 0 1 %0d",
                     n, running, grst, gamma_count, cnt0 + 1);
        end
    endtask

    task automatic test_rst_mid();
        start = 1'b1;
        for (int k = 0; k < 64 && !(m_run && m_phase == 9); k++) step();
        checks++;
        if (phase !== 4'd9 || running !== 1'b1) begin
            errors++; $display("FAIL reach_phase9: got ph=%0d run=%b want 9 1", phase, running);
        end
        rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if (grst !== 1'b1 || running !== 1'b0 || phase !== 4'd0 || lane_spike !== 4'd0 ||
            gamma_count !== 16'd0 || cfg_err !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: got grst=%b run=%b ph=%0d sp=%b cnt=%0d err=%b rdy=%b want 1 0 0 0000 0 0 1",
                     grst, running, phase, lane_spike, gamma_count, cfg_err, cfg_bus.cfg_ready);
        end
        step();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL rst_hold_vec: got %h want %h", obs, exp_vec());
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        set_cfg(0, 0, 0, 0);
        m_reset();
        test_reset();
        test_idle_config();
        test_start();
        test_late_lane();
        test_midcycle_write();
        test_commit_stall();
        test_random();
        test_stop();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
